// File: rtl/io_bus_ctrl_if.sv
// Device-side handshake bus between io_bus_ctrl (master) and the IO peripherals (slave).
interface io_bus_ctrl_if;
   logic [3:0]  dev_sel;
   logic        dev_req;
   logic        dev_we;
   logic [3:0]  dev_addr;
   logic [31:0] dev_wdata;
   logic [31:0] dev_rdata;
   logic        dev_ack;

   modport master (
      output dev_sel, dev_req, dev_we, dev_addr, dev_wdata,
      input  dev_rdata, dev_ack
   );

   modport slave (
      input  dev_sel, dev_req, dev_we, dev_addr, dev_wdata,
      output dev_rdata, dev_ack
   );
endinterface

// File: rtl/io_bus_ctrl.sv
// CPU-to-peripheral IO bridge: decodes the IO page, runs a req/ack handshake and
// stalls the CPU until it completes. Define IO_BUS_TIMEOUT_EN to abort stuck requests.
module io_bus_ctrl #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          io_read,
   input  logic          io_write,
   input  logic [9:0]    addr_low,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          cpu_stall,
   output logic          bus_err,
   output logic [7:0]    err_count,
   io_bus_ctrl_if.master bus
);
   localparam int unsigned SEL_W = 4;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t           state;
   logic [SEL_W-1:0] sel;
   logic             strobe;
`ifdef IO_BUS_TIMEOUT_EN
   logic [CNT_W-1:0] tmo_cnt;
`endif

   assign strobe    = io_read | io_write;
   assign cpu_stall = (state == ST_REQ) || ((state == ST_IDLE) && strobe);

   // IO page decode; zero means unmapped
   always_comb begin
      sel = '0;
      case (addr_low[9:4])
         6'h06:   sel = 4'b0001;
         6'h07:   sel = 4'b0010;
         6'h08:   sel = 4'b0100;
         6'h09:   sel = 4'b1000;
         default: sel = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         bus.dev_req   <= 1'b0;
         bus.dev_we    <= 1'b0;
         bus.dev_sel   <= '0;
         bus.dev_addr  <= '0;
         bus.dev_wdata <= '0;
         rdata         <= '0;
         bus_err       <= 1'b0;
         err_count     <= '0;
`ifdef IO_BUS_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         bus_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (strobe) begin
                  if (sel != '0) begin
                     // a simultaneous read+write is treated as a write
                     bus.dev_sel   <= sel;
                     bus.dev_addr  <= addr_low[3:0];
                     bus.dev_we    <= io_write;
                     bus.dev_wdata <= wdata;
                     bus.dev_req   <= 1'b1;
`ifdef IO_BUS_TIMEOUT_EN
                     tmo_cnt       <= '0;
`endif
                     state         <= ST_REQ;
                  end else begin
                     rdata   <= '0;
                     bus_err <= 1'b1;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                     state   <= ST_ERR;
                  end
               end
            end
            ST_REQ: begin
               if (bus.dev_ack) begin
                  bus.dev_req <= 1'b0;
                  if (!bus.dev_we) rdata <= bus.dev_rdata;
                  state <= ST_DONE;
`ifdef IO_BUS_TIMEOUT_EN
               end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 8'd1)) begin
                  // limit reached without ack: abort as a bus error
                  bus.dev_req <= 1'b0;
                  rdata       <= '0;
                  bus_err     <= 1'b1;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  state       <= ST_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
               end
            end
            ST_DONE: state <= ST_IDLE;
            ST_ERR:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Randomized self-checking bench for io_bus_ctrl against a transaction-level model.
module tb_io_bus_ctrl;
`ifdef IO_BUS_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
   localparam int TMO    = 4;
`else
   localparam bit TMO_ON = 1'b0;
   localparam int TMO    = 200;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        io_read = 1'b0;
   logic        io_write = 1'b0;
   logic [9:0]  addr_low = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        cpu_stall;
   logic        bus_err;
   logic [7:0]  err_count;

   io_bus_ctrl_if bus_if ();

   io_bus_ctrl #(.TIMEOUT_CYCLES(8'(TMO))) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .io_read   (io_read),
      .io_write  (io_write),
      .addr_low  (addr_low),
      .wdata     (wdata),
      .rdata     (rdata),
      .cpu_stall (cpu_stall),
      .bus_err   (bus_err),
      .err_count (err_count),
      .bus       (bus_if)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] m_rdata  = '0;
   int          m_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   // One CPU IO access; ack_at is the REQ cycle (1-based) carrying dev_ack, 0 = never
   task automatic run_txn(input bit rd, input bit wr, input logic [9:0] a,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] rdv);
      int         page   = int'(a[9:4]);
      bit         mapped = (page >= 6) && (page <= 9);
      bit         tmo    = mapped && TMO_ON && ((ack_at == 0) || (ack_at > TMO));
      logic [3:0] e_sel  = mapped ? 4'(1 << (page - 6)) : 4'b0000;
      int         e_req  = !mapped ? 0 : (tmo ? TMO : ack_at);
      int         stalls = 0;
      int         reqc   = 0;
      bit         stable = 1'b1;

      if (!mapped || tmo) begin
         m_rdata = '0;
         if (m_err < 255) m_err++;
      end else if (!wr) begin
         m_rdata = rdv;
      end

      @(negedge clock);
      io_read = rd; io_write = wr; addr_low = a; wdata = wd;
      bus_if.dev_rdata = rdv;
      bus_if.dev_ack   = 1'b1;
      #1;
      for (int c = 0; c < 2000 && cpu_stall; c++) begin
         stalls++;
         if (bus_if.dev_req) begin
            reqc++;
            if (bus_if.dev_sel !== e_sel || bus_if.dev_addr !== a[3:0] ||
                bus_if.dev_we !== wr || bus_if.dev_wdata !== wd) stable = 1'b0;
            bus_if.dev_ack = (reqc == ack_at);
         end else begin
            bus_if.dev_ack = 1'b1;
         end
         @(negedge clock);
      end

      check("stall_cycles", 32'(stalls), 32'(mapped ? e_req + 1 : 1));
      check("req_cycles", 32'(reqc), 32'(e_req));
      check("dev_req_end", 32'(bus_if.dev_req), 32'(0));
      check("bus_err", 32'(bus_err), 32'(!mapped || tmo));
      check("rdata", rdata, m_rdata);
      check("err_count", 32'(err_count), 32'(m_err));
      if (mapped) begin
         check("dev_sel", 32'(bus_if.dev_sel), 32'(e_sel));
         check("dev_addr", 32'(bus_if.dev_addr), 32'(a[3:0]));
         check("dev_we", 32'(bus_if.dev_we), 32'(wr));
         check("dev_wdata", bus_if.dev_wdata, wd);
         check("req_stable", 32'(stable), 32'(1));
      end

      io_read = 1'b0; io_write = 1'b0;
      bus_if.dev_ack = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("idle_stall", 32'(cpu_stall), 32'(0));
      check("err_pulse_end", 32'(bus_err), 32'(0));
      check("rdata_hold", rdata, m_rdata);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_dev_req"}, 32'(bus_if.dev_req), 32'(0));
      check({tag, "_dev_sel"}, 32'(bus_if.dev_sel), 32'(0));
      check({tag, "_dev_addr"}, 32'(bus_if.dev_addr), 32'(0));
      check({tag, "_dev_we"}, 32'(bus_if.dev_we), 32'(0));
      check({tag, "_dev_wdata"}, bus_if.dev_wdata, 32'(0));
      check({tag, "_rdata"}, rdata, 32'(0));
      check({tag, "_bus_err"}, 32'(bus_err), 32'(0));
      check({tag, "_err_count"}, 32'(err_count), 32'(0));
   endtask

   initial begin
      bus_if.dev_ack   = 1'b0;
      bus_if.dev_rdata = '0;
      #2 reset_n = 1'b0;
      #1;
      reset_checks("por");
      check("por_stall", 32'(cpu_stall), 32'(0));
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      run_txn(1'b1, 1'b0, 10'h070, 32'hDEAD_BEEF, 1, 32'h0000_00A5);
      run_txn(1'b0, 1'b1, 10'h062, 32'h1234_5678, 3, 32'hFFFF_0000);
      run_txn(1'b1, 1'b0, 10'h3F0, 32'h0, 1, 32'h5555_5555);
      run_txn(1'b1, 1'b1, 10'h08C, 32'hCAFE_F00D, 2, 32'h7777_7777);
`ifdef IO_BUS_TIMEOUT_EN
      run_txn(1'b1, 1'b0, 10'h095, 32'h0, 0, 32'h1111_1111);
      run_txn(1'b1, 1'b0, 10'h071, 32'h0, TMO, 32'h2222_2222);
`endif

      for (int i = 0; i < 40; i++) begin
         int          op  = int'($urandom_range(0, 3));
         logic [9:0]  a   = 10'($urandom);
         int          ack = TMO_ON ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
         if ($urandom_range(0, 3) != 0) a = {6'(6 + $urandom_range(0, 3)), 4'($urandom)};
         run_txn(op != 1, op == 1 || op == 2, a, $urandom, ack, $urandom);
      end

`ifndef IO_BUS_TIMEOUT_EN
      // Without timeout a silent peripheral stalls the CPU indefinitely
      @(negedge clock);
      io_read = 1'b1; addr_low = 10'h080; bus_if.dev_ack = 1'b0;
      repeat (1000) @(negedge clock);
      check("hang_stall", 32'(cpu_stall), 32'(1));
      check("hang_req", 32'(bus_if.dev_req), 32'(1));
      io_read = 1'b0;
      reset_n = 1'b0;
      m_rdata = '0; m_err = 0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
`endif

      // Reset in the second REQ cycle
      run_txn(1'b1, 1'b0, 10'h091, 32'h0, 1, 32'hA5A5_0001);
      @(negedge clock);
      io_read = 1'b1; addr_low = 10'h093; wdata = 32'h0BAD_CAFE; bus_if.dev_ack = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("mid_req_before_rst", 32'(bus_if.dev_req), 32'(1));
      #1 reset_n = 1'b0;
      #1;
      m_rdata = '0; m_err = 0;
      reset_checks("mid");
      check("mid_stall_idle_strobe", 32'(cpu_stall), 32'(1));
      io_read = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_if.dev_ack = 1'b1;
         @(negedge clock);
         check("stray_ack_req", 32'(bus_if.dev_req), 32'(0));
         check("stray_ack_stall", 32'(cpu_stall), 32'(0));
         check("stray_ack_rdata", rdata, 32'(0));
      end

      // Saturating error counter
      for (int i = 0; i < 300; i++) run_txn(1'b1, 1'b0, 10'h3F0, 32'h0, 1, 32'h0);
      check("err_saturated", 32'(err_count), 32'h0000_00FF);
      run_txn(1'b1, 1'b0, 10'h07F, 32'h0, 2, 32'h0000_0042);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
